// File: rtl/lod_norm_arbiter_if.sv
// Requester and result ports of the shared leading-one normalizer.
// The master side drives operands and consumes results; the slave side is the normalizer.
interface lod_norm_arbiter_if #(
    parameter int N    = 16,
    parameter int NREQ = 4
);
    localparam int LZW = $clog2(N) + 1;
    localparam int TW  = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_norm;
    logic [LZW-1:0]    out_lzc;
    logic              out_zero;
    logic [TW-1:0]     out_tag;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_norm, out_lzc, out_zero, out_tag
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_norm, out_lzc, out_zero, out_tag
    );
endinterface

// File: rtl/lod_norm_arbiter.sv
// Shared leading-one normalizer with round-robin arbitration across NREQ requesters.
//
// state  | meaning
// IDLE   | arbitrate; grant one valid requester and capture its operand
// DETECT | leading-one detect on the captured operand, compute lzc
// SHIFT  | shift operand left by lzc, load result registers, raise out_valid
// HOLD   | hold result until out_ready; then return to IDLE
module lod_norm_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input logic               clk,
    input logic               rst_n,
    lod_norm_arbiter_if.slave bus
);
    localparam int LZW = $clog2(N) + 1;
    localparam int IW  = $clog2(N);
    localparam int TW  = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, DETECT, SHIFT, HOLD} state_t;

    state_t         state_q;
    logic [TW-1:0]  ptr_q;
    logic [TW-1:0]  tag_q;
    logic [N-1:0]   opnd_q;
    logic [LZW-1:0] lzc_q;
    logic           out_valid_q;
    logic [N-1:0]   out_norm_q;
    logic [LZW-1:0] out_lzc_q;
    logic           out_zero_q;
    logic [TW-1:0]  out_tag_q;

    logic           gnt_found_d;
    logic [TW-1:0]  gnt_idx_d;
    logic [NREQ-1:0] gnt_oh_d;
    logic [N-1:0]   sel_data_d;
    logic [N-1:0]   lead_oh_d;
    logic [IW-1:0]  lead_idx_d;
    logic [LZW-1:0] lzc_d;
    logic           xfer;

    // Round-robin search starting at ptr; power-of-two NREQ makes the wrap a plain overflow.
    always_comb begin
        logic [TW-1:0] cand;
        cand        = '0;
        gnt_found_d = 1'b0;
        gnt_idx_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + TW'(k);
            if (!gnt_found_d && bus.req_valid[cand]) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = cand;
            end
        end
    end

    // One-hot grant vector and the operand of the granted requester.
    always_comb begin
        gnt_oh_d   = '0;
        sel_data_d = '0;
        if (gnt_found_d) gnt_oh_d[gnt_idx_d] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx_d == TW'(i)) sel_data_d = bus.req_data[i*N +: N];
        end
    end

    assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt_oh_d : '0;
    assign xfer          = |(bus.req_valid & bus.req_ready);

    // One-hot leading-one detect on the captured operand, then encode to lzc.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        lead_oh_d  = '0;
        lead_idx_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!seen && opnd_q[i]) begin
                lead_oh_d[i] = 1'b1;
                seen         = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (lead_oh_d[i]) lead_idx_d = lead_idx_d | IW'(i);
        end
        if (lead_oh_d == '0) lzc_d = LZW'(N);
        else                 lzc_d = LZW'(N - 1) - {1'b0, lead_idx_d};
    end

    // Sequencer with registered outputs; reset drops any in-flight operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            tag_q       <= '0;
            opnd_q      <= '0;
            lzc_q       <= '0;
            out_valid_q <= 1'b0;
            out_norm_q  <= '0;
            out_lzc_q   <= '0;
            out_zero_q  <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        opnd_q  <= sel_data_d;
                        tag_q   <= gnt_idx_d;
                        ptr_q   <= gnt_idx_d + TW'(1);
                        state_q <= DETECT;
                    end
                end
                DETECT: begin
                    lzc_q   <= lzc_d;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    out_norm_q  <= opnd_q << lzc_q;
                    out_lzc_q   <= lzc_q;
                    out_zero_q  <= (opnd_q == '0);
                    out_tag_q   <= tag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_norm  = out_norm_q;
    assign bus.out_lzc   = out_lzc_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_lod_norm_arbiter.sv
// Directed bench for lod_norm_arbiter: reset, single ops, zero/MSB, fairness,
// pointer wrap, backpressure and mid-operation reset.
module tb_lod_norm_arbiter;
    logic clk;
    logic rst_n;
    int   nchk;
    int   nerr;

    lod_norm_arbiter_if #(.N(16), .NREQ(4)) bus ();

    lod_norm_arbiter #(.N(16), .NREQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, " valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " norm"},  32'(bus.out_norm),  32'd0);
        chk({tag, " lzc"},   32'(bus.out_lzc),   32'd0);
        chk({tag, " zero"},  32'(bus.out_zero),  32'd0);
        chk({tag, " tag"},   32'(bus.out_tag),   32'd0);
    endtask

    task automatic chk_result(input string tag, input logic [15:0] e_norm, input logic [4:0] e_lzc,
                              input logic e_zero, input logic [1:0] e_tag);
        chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " norm"},  32'(bus.out_norm),  32'(e_norm));
        chk({tag, " lzc"},   32'(bus.out_lzc),   32'(e_lzc));
        chk({tag, " zero"},  32'(bus.out_zero),  32'(e_zero));
        chk({tag, " tag"},   32'(bus.out_tag),   32'(e_tag));
    endtask

    // One full operation from an IDLE cycle with out_ready = 1; ends in the next IDLE cycle.
    task automatic run_one(input string tag, input logic [3:0] v, input logic [3:0] e_gnt,
                           input logic [15:0] e_norm, input logic [4:0] e_lzc,
                           input logic e_zero, input logic [1:0] e_tag);
        bus.req_valid = v;
        #1;
        chk({tag, " grant"}, 32'(bus.req_ready), 32'(e_gnt));
        cyc();
        bus.req_valid = '0;
        chk({tag, " detect valid"}, 32'(bus.out_valid), 32'd0);
        cyc();
        chk({tag, " shift valid"}, 32'(bus.out_valid), 32'd0);
        cyc();
        chk_result(tag, e_norm, e_lzc, e_zero, e_tag);
        chk({tag, " hold ready"}, 32'(bus.req_ready), 32'd0);
        cyc();
        chk({tag, " valid drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        nchk          = 0;
        nerr          = 0;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;

        // Reset state, with requests pending
        cyc();
        cyc();
        #1;
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        chk_zero_outs("reset");
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        cyc();

        // Single request, then zero and MSB operands (ptr 0 -> 1 -> 3 -> 2)
        bus.req_data[0*16 +: 16] = 16'h0300;
        run_one("single", 4'b0001, 4'b0001, 16'hC000, 5'd6, 1'b0, 2'd0);
        bus.req_data[2*16 +: 16] = 16'h0000;
        run_one("zero", 4'b0100, 4'b0100, 16'h0000, 5'd16, 1'b1, 2'd2);
        bus.req_data[1*16 +: 16] = 16'h8001;
        run_one("msb", 4'b0010, 4'b0010, 16'h8001, 5'd0, 1'b0, 2'd1);

        // Pointer wrap: req 3 alone (ptr 2 -> 0), then 1010 grants 1 then 3
        bus.req_data[3*16 +: 16] = 16'h0001;
        run_one("wrap3", 4'b1000, 4'b1000, 16'h8000, 5'd15, 1'b0, 2'd3);
        bus.req_data[1*16 +: 16] = 16'h0010;
        bus.req_data[3*16 +: 16] = 16'h00F0;
        run_one("wrap1", 4'b1010, 4'b0010, 16'h8000, 5'd11, 1'b0, 2'd1);
        run_one("wrap3b", 4'b1010, 4'b1000, 16'hF000, 5'd8, 1'b0, 2'd3);

        // Round-robin fairness with all requesters held valid (ptr 0)
        for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'(1 << i);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            cyc();
            chk("rr detect valid", 32'(bus.out_valid), 32'd0);
            cyc();
            chk("rr shift valid", 32'(bus.out_valid), 32'd0);
            cyc();
            chk_result("rr", 16'h8000, 5'(15 - (k % 4)), 1'b0, 2'(k % 4));
            cyc();
        end

        // Backpressure: ptr is 2, all requesters still valid
        bus.req_data[2*16 +: 16] = 16'h0003;
        bus.out_ready = 1'b0;
        #1;
        chk("bp grant", 32'(bus.req_ready), 32'b0100);
        cyc();
        cyc();
        cyc();
        chk_result("bp first", 16'hC000, 5'd14, 1'b0, 2'd2);
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk_result("bp hold", 16'hC000, 5'd14, 1'b0, 2'd2);
            chk("bp ready", 32'(bus.req_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp accept ready", 32'(bus.req_ready), 32'd0);
        cyc();
        chk("bp after valid", 32'(bus.out_valid), 32'd0);
        chk("bp after norm", 32'(bus.out_norm), 32'hC000);
        chk("bp next grant", 32'(bus.req_ready), 32'b1000);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();
        chk_result("bp next", 16'h8000, 5'd12, 1'b0, 2'd3);
        cyc();

        // Reset while in DETECT (ptr 0 -> grant 2, operand dropped)
        bus.req_valid = 4'b0100;
        #1;
        chk("rstdet grant", 32'(bus.req_ready), 32'b0100);
        cyc();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("rstdet ready", 32'(bus.req_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        chk_zero_outs("rstdet");
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("rstdet no result", 32'(bus.out_valid), 32'd0);
        end
        bus.req_data[1*16 +: 16] = 16'h0002;
        run_one("rstdet next", 4'b1010, 4'b0010, 16'h8000, 5'd14, 1'b0, 2'd1);

        // Reset while in HOLD (ptr 2 -> grant 1, operand dropped; ptr 0 afterwards)
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        chk("rsthold grant", 32'(bus.req_ready), 32'b0010);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();
        chk_result("rsthold pend", 16'h8000, 5'd14, 1'b0, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("rsthold ready", 32'(bus.req_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        chk_zero_outs("rsthold");
        bus.out_ready = 1'b1;
        bus.req_data[0*16 +: 16] = 16'h0300;
        cyc();
        chk("rsthold no result", 32'(bus.out_valid), 32'd0);
        run_one("rsthold next", 4'b1001, 4'b0001, 16'hC000, 5'd6, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/lod_norm_arbiter.md
# lod_norm_arbiter

Shared leading-one normalizer with round-robin arbitration. Up to NREQ requesters submit N-bit unsigned operands over valid/ready. The block grants one at a time, runs the operand through a single leading-one detect and shift datapath, and returns the normalized value, leading-zero count and requester tag over a valid/ready output port. It sits in front of the fixed-point log/reciprocal stages of the renderer so that those stages share one normalizer instead of instantiating one each.

## Interface
- N, 16, operand width in bits; N ≥ 2, power of two.
- NREQ, 4, number of requesters; NREQ ≥ 2, power of two.
- LZW, $clog2(N)+1, width of the leading-zero count (5 for N=16).
- TW, $clog2(NREQ), width of the requester tag.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*N  operand for requester i at [i*N +: N].
- req_ready  out  NREQ  per-requester grant/ready; at most one bit set.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_norm  out  N  operand shifted left by out_lzc; MSB = 1 unless zero.
- out_lzc  out  LZW  leading-zero count, 0..N.
- out_zero  out  1  operand was zero.
- out_tag  out  TW  index of the requester that produced the result.

## Operation
- FSM states: IDLE, DETECT, SHIFT, HOLD. Reset state is IDLE.
- IDLE:
  - req_ready is combinational, one-hot on the granted requester.
  - The grant goes to the first i with req_valid[i], searching ptr, ptr+1, … with wrap mod NREQ.
  - If no req_valid bit is set, req_ready = 0 and the FSM stays in IDLE.
- Transfer happens when req_valid[g] && req_ready[g]. On transfer:
  - operand ← req_data[g], tag ← g, ptr ← (g+1) mod NREQ.
  - Next state: DETECT.
- ptr changes only on a transfer; it resets to 0.
- DETECT:
  - A one-hot leading-one detect is applied to the registered operand; the highest set bit wins.
  - lzc ← N−1−(index of leading one); zero operand gives lzc = N.
  - Next state: SHIFT.
- SHIFT:
  - out_norm ← operand << lzc (0 when zero), out_lzc ← lzc, out_zero ← (operand == 0), out_tag ← tag.
  - out_valid ← 1. Next state: HOLD.
- HOLD:
  - All out_* hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid ← 0 and next state IDLE. out_norm, lzc, zero and tag keep their last values.
- req_ready = 0 in every state except IDLE, and while rst_n = 0.
- A requester dropping req_valid before grant is legal; it is simply not granted.
- req_data is sampled only on the transfer edge.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, ptr = 0, out_valid = 0, out_norm = 0, out_lzc = 0, out_zero = 0, out_tag = 0.
  - req_ready = 0 while rst_n is low.
- Latency: transfer at edge t gives out_valid = 1 after edge t+2, so it is visible in cycle t+3 relative to the grant cycle t.
- Throughput: minimum 4 cycles per operation (IDLE, DETECT, SHIFT, HOLD with out_ready = 1 in the first HOLD cycle).
- Result acceptance and the next grant never share a cycle. The grant occurs in the IDLE cycle after acceptance.
- Simultaneous requests: exactly one grant per IDLE cycle. A continuously valid requester waits at most NREQ−1 other operations.
- Reset mid-operation (any state): the in-flight operand is dropped and no result is emitted. The next cycle is IDLE with ptr = 0.
- out_ready is ignored outside HOLD.

## Test plan
- Single request: reset, then req_valid = 0001, req_data[0] = 0x0300, out_ready = 1.
  - Expect req_ready = 0001 that cycle; out_valid 3 cycles later.
  - Expect out_norm = 0xC000, out_lzc = 6, out_zero = 0, out_tag = 0.
  - out_valid lasts 1 cycle.
- Zero and MSB cases:
  - req 2 with 0x0000: expect out_lzc = 16, out_norm = 0x0000, out_zero = 1, out_tag = 2.
  - req 1 with 0x8001: expect out_lzc = 0, out_norm = 0x8001, out_zero = 0.
- Round-robin fairness: all req_valid = 1111 held high, req_data[i] = 1<<i, out_ready = 1.
  - Expect tags 0,1,2,3,0,1 in order, lzc 15,14,13,12,15,…, out_norm = 0x8000 each time.
  - Expect one result every 4 cycles.
- Pointer wrap: first grant req 3 only (ptr → 0), then assert 1010.
  - Expect grant to req 1, then ptr = 2, then req 3.
- Backpressure: result pending with out_ready = 0 for 10 cycles while other requesters are valid.
  - Expect out_* stable and req_ready = 0 throughout.
  - Raise out_ready: expect acceptance, then a grant in the following cycle.
- Reset mid-op: assert rst_n = 0 for one edge while in DETECT (and again in HOLD).
  - Expect out_valid = 0 and all outputs 0 next cycle, no result for the dropped operand.
  - Expect the next grant to follow ptr = 0 priority.
